seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low, with ports named clk and reset.
REQ-002 The port clk SHALL be an input, 1 bit wide: the rising-edge clock for all state.
REQ-003 The port reset SHALL be an input, 1 bit wide: synchronous, active-low; when 0 at a rising edge, all state initialises.
REQ-004 The port start SHALL be an input, 1 bit wide: a request to begin a signed division; it is sampled only in IDLE.
REQ-005 The port dividend SHALL be an input, 32 bits wide: the signed dividend, captured on the accepting edge (it is the value from the A register).
REQ-006 The port divisor SHALL be an input, 32 bits wide: the signed divisor, captured on the accepting edge (it is the value from the B register).
REQ-007 The port hi SHALL be an output, 32 bits wide: the registered remainder, fed to the HI mux.
REQ-008 The port lo SHALL be an output, 32 bits wide: the registered quotient, fed to the LO mux.
REQ-009 The port busy SHALL be an output, 1 bit wide: high from the cycle after acceptance until done.
REQ-010 The port done SHALL be an output, 1 bit wide: a single-cycle completion pulse.
REQ-011 The port div_zero SHALL be an output, 1 bit wide: a single-cycle pulse, coincident with done, reporting a divisor of zero.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC, FIX and FINISH, encoded in 2 bits.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch the operands, record the sign of each, and load their absolute values as 32-bit unsigned numbers (0x80000000 stays 0x80000000).
REQ-014 At E0, a nonzero divisor SHALL move the FSM to CALC and clear the 6-bit iteration counter.
REQ-015 At E0, a divisor of zero SHALL move the FSM straight to FINISH with a zero flag set; hi and lo SHALL NOT be updated in that case.
REQ-016 In CALC, each edge SHALL perform one restoring step: shift {rem, quo} left by 1 and trial-subtract |divisor| from rem; if the result is non-negative, rem is replaced and the quotient LSB is set to 1, otherwise the quotient LSB is 0.
REQ-017 CALC SHALL last exactly 32 edges (E1..E32), with the counter going 0..31; after the 32nd step the FSM SHALL go to FIX.
REQ-018 In FIX (edge E33), lo SHALL receive the quotient, negated when the operand signs differ.
REQ-019 In FIX (edge E33), hi SHALL receive the remainder, negated when the dividend is negative.
REQ-020 Quotient SHALL truncate toward zero, matching MIPS DIV.
REQ-021 FIX SHALL go to FINISH.
REQ-022 In FINISH, done SHALL be 1 for exactly one cycle, and div_zero SHALL be 1 in that same cycle if the zero flag is set; the next edge SHALL return the FSM to IDLE and clear the flag.
REQ-023 A normal division SHALL assert done in the 34th cycle after E0 (the cycle following E33).
REQ-024 A zero-divisor division SHALL assert done in the cycle following E0.
REQ-025 busy SHALL be 1 in CALC, FIX and FINISH, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no queuing.
REQ-027 Changes to dividend or divisor after E0 SHALL NOT affect the result.
REQ-028 hi and lo SHALL hold their values between completions and across zero-divisor operations.
REQ-029 The case 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag raised.
REQ-030 start in the FINISH cycle SHALL be ignored; a new operation is accepted no earlier than the following IDLE cycle.

Reset
REQ-031 On reset=0 at a rising edge, the FSM SHALL go to IDLE; hi, lo, the internal rem/quo/operand registers, the counter and the zero flag SHALL become 0; busy, done and div_zero SHALL be 0.
REQ-032 Reset SHALL take priority over all other activity, including reset mid-CALC or mid-FIX; an aborted division SHALL produce no done pulse.
REQ-033 Reset SHALL be held for at least 1 edge; start SHALL be honoured from the first edge with reset=1.

Verification
REQ-034 The bench SHALL cover: 7 / 2 -> done at E0+34 cycles, lo=0x00000003, hi=0x00000001, div_zero=0.
REQ-035 The bench SHALL cover: -7 / 2 and 7 / -2 -> respectively lo=0xFFFFFFFD with hi=0xFFFFFFFF, and lo=0xFFFFFFFD with hi=0x00000001.
REQ-036 The bench SHALL cover: hi/lo preloaded with 5/1, then 9 / 0 -> done and div_zero both 1 in the cycle after E0, with hi=0x00000001 and lo=0x00000005 unchanged.
REQ-037 The bench SHALL cover: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; and 0 / 5 -> lo=0, hi=0.
REQ-038 The bench SHALL cover: start 100/7 with a second start (operands 1/1) pulsed at cycle 5 and the operands changed at cycle 6 -> one done only, lo=14, hi=2.
REQ-039 The bench SHALL cover: reset=0 at cycle 10 of CALC -> next cycle busy=0, hi=lo=0, no done; a fresh 7/2 then completes normally.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/start request and result/status bundle of the divider
interface seq_divider_if;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;
   modport master (output start, dividend, divisor, input hi, lo, busy, done, div_zero);
   modport slave (input start, dividend, divisor, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 32-bit signed restoring divider, one quotient bit per cycle, MIPS DIV semantics
module seq_divider (
   input logic          clk,
   input logic          reset,
   seq_divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;
   state_t      state;
   logic [31:0] rem, quo, dvs, a_abs, b_abs;
   logic [32:0] diff;
   logic [5:0]  cnt;
   logic        sign_a, sign_b, zero_flag;
   always_comb begin
      a_abs = bus.dividend[31] ? -bus.dividend : bus.dividend;
      b_abs = bus.divisor[31] ? -bus.divisor : bus.divisor;
      diff  = {rem, quo[31]} - {1'b0, dvs};
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         rem          <= '0;
         quo          <= '0;
         dvs          <= '0;
         cnt          <= '0;
         sign_a       <= 1'b0;
         sign_b       <= 1'b0;
         zero_flag    <= 1'b0;
         bus.hi       <= '0;
         bus.lo       <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               sign_a   <= bus.dividend[31];
               sign_b   <= bus.divisor[31];
               quo      <= a_abs;
               rem      <= '0;
               dvs      <= b_abs;
               cnt      <= '0;
               bus.busy <= 1'b1;
               if (b_abs == '0) begin
                  zero_flag    <= 1'b1;
                  bus.done     <= 1'b1;
                  bus.div_zero <= 1'b1;
                  state        <= FINISH;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               // diff[32] set means the trial subtraction went negative: restore
               rem   <= diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
               quo   <= {quo[30:0], ~diff[32]};
               cnt   <= cnt + 6'd1;
               state <= (cnt == 6'd31) ? FIX : CALC;
            end
            FIX: begin
               bus.lo       <= (sign_a ^ sign_b) ? -quo : quo;
               bus.hi       <= sign_a ? -rem : rem;
               bus.done     <= 1'b1;
               bus.div_zero <= zero_flag;
               state        <= FINISH;
            end
            default: begin
               bus.done     <= 1'b0;
               bus.div_zero <= 1'b0;
               bus.busy     <= 1'b0;
               zero_flag    <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboarded random and directed checks of seq_divider against 64-bit arithmetic
module tb_seq_divider;
   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          cyc;
   } exp_t;
   logic clk, reset;
   int   cyc = 0, checks = 0, errors = 0, n_done = 0, n_issued = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;
   exp_t sb[$];
   exp_t me;
   seq_divider_if bus ();
   seq_divider dut (.clk(clk), .reset(reset), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.div_zero && !bus.done) check("div_zero_without_done", bus.done, 1'b1);
      if (bus.done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", {31'b0, bus.done}, 32'd0);
         end else begin
            me = sb.pop_front();
            check("lo", bus.lo, me.lo);
            check("hi", bus.hi, me.hi);
            check("div_zero", {31'b0, bus.div_zero}, {31'b0, me.dz});
            check("done_cycle", cyc, me.cyc);
         end
      end
   end
   task automatic wait_idle();
      @(negedge clk);
      for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
      if (bus.busy) check("idle_timeout", {31'b0, bus.busy}, 32'd0);
   endtask
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int c0);
      exp_t   e;
      longint q, r;
      wait_idle();
      c0 = cyc + 1;
      if (b == '0) begin
         e.lo = exp_lo;
         e.hi = exp_hi;
         e.dz = 1'b1;
         e.cyc = c0;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
         e.lo = q[31:0];
         e.hi = r[31:0];
         e.dz = 1'b0;
         e.cyc = c0 + 33;
         exp_lo = e.lo;
         exp_hi = e.hi;
      end
      sb.push_back(e);
      n_issued++;
      bus.start = 1'b1;
      bus.dividend = a;
      bus.divisor = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = $urandom;
      bus.divisor = $urandom;
   endtask
   function automatic logic [31:0] pick();
      logic [31:0] s;
      s = 32'($urandom_range(0, 20));
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return s;
         4: return -s;
         default: return $urandom;
      endcase
   endfunction
   initial begin
      int c0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_div_zero", {31'b0, bus.div_zero}, 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      reset = 1'b1;
      do_div(32'd7, 32'd2, c0);
      do_div(-32'sd7, 32'd2, c0);
      do_div(32'd7, -32'sd2, c0);
      do_div(32'd16, 32'd3, c0);
      do_div(32'd9, 32'd0, c0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, c0);
      do_div(32'd0, 32'd5, c0);
      // a second start while busy must be dropped, then operands scrambled
      do_div(32'd100, 32'd7, c0);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 32'd1;
      bus.divisor = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = 32'd55;
      bus.divisor = 32'd0;
      do_div(32'd123456, 32'd77, c0);
      repeat (9) @(negedge clk);
      n_issued -= sb.size();
      sb.delete();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_done", {31'b0, bus.done}, 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      reset = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      do_div(32'd7, 32'd2, c0);
      for (int i = 0; i < 40; i++) do_div(pick(), pick(), c0);
      wait_idle();
      repeat (5) @(negedge clk);
      check("done_count", n_done, n_issued);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
